// File: rtl/enemy_slot_scheduler_pkg.sv
// enemy_slot_scheduler_pkg: shared playfield geometry, FSM encoding and axis step helper
package enemy_slot_scheduler_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BULLET_W = 5;
    localparam int BULLET_H = 10;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    // Move p toward t by spd without overshooting, then cap at lim; 11 bits keep sums from wrapping
    function automatic logic [9:0] step_axis(input logic [9:0] p, input logic [9:0] t,
                                             input logic [10:0] spd, input logic [10:0] lim);
        logic [10:0] a, b, r;
        a = {1'b0, p};
        b = {1'b0, t};
        r = (a < b) ? ((a + spd > b) ? b : a + spd) : ((a - b > spd) ? a - spd : b);
        r = (r > lim) ? lim : r;
        return r[9:0];
    endfunction

endpackage

// File: rtl/enemy_slot_scheduler_step.sv
// enemy_step: bullet overlap test and one movement step for a single enemy slot
module enemy_step
    import enemy_slot_scheduler_pkg::*;
#(
    parameter int ENEMY_SPEED = 2,
    parameter int ENEMY_SIZE  = 20
) (
    input  logic [9:0] ex,
    input  logic [9:0] ey,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       bullet_active,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    output logic       hit,
    output logic [9:0] nx,
    output logic [9:0] ny
);

    localparam logic [10:0] SPD   = 11'(ENEMY_SPEED);
    localparam logic [10:0] SZ    = 11'(ENEMY_SIZE);
    localparam logic [10:0] LIM_X = 11'(SCREEN_W - ENEMY_SIZE);
    localparam logic [10:0] LIM_Y = 11'(SCREEN_H - ENEMY_SIZE);

    logic [10:0] ex1, ey1, bx1, by1;

    // Rectangle overlap against the bullet and clamped step toward the player
    always_comb begin
        ex1 = {1'b0, ex};
        ey1 = {1'b0, ey};
        bx1 = {1'b0, bx};
        by1 = {1'b0, by};
        hit = bullet_active && (bx1 + 11'(BULLET_W) > ex1) && (bx1 < ex1 + SZ)
                            && (by1 + 11'(BULLET_H) > ey1) && (by1 < ey1 + SZ);
        nx  = step_axis(ex, px, SPD, LIM_X);
        ny  = step_axis(ey, py, SPD, LIM_Y);
    end

endmodule

// File: rtl/enemy_slot_scheduler.sv
// enemy_slot_scheduler: sweeps enemy slots one per cycle for movement, bullet hits and spawning
module enemy_slot_scheduler
    import enemy_slot_scheduler_pkg::*;
#(
    parameter int MAX_ENEMIES = 10,
    parameter int ENEMY_SPEED = 2,
    parameter int ENEMY_SIZE  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       spawn_en,
    input  logic [9:0] rand_val,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       bullet_active,
    input  logic [9:0] bullet_x,
    input  logic [9:0] bullet_y,
    input  logic [3:0] rd_idx,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic       rd_active,
    output logic       busy,
    output logic       done,
    output logic       hit_pulse,
    output logic [3:0] hit_slot,
    output logic [4:0] active_count,
    output logic       overrun
);

    localparam logic [4:0] NSLOT   = 5'(MAX_ENEMIES);
    localparam logic [3:0] LAST    = 4'(MAX_ENEMIES - 1);
    localparam logic [9:0] SPAWN_W = 10'(SCREEN_W - ENEMY_SIZE);
    localparam logic [9:0] SPAWN_H = 10'(SCREEN_H - ENEMY_SIZE);

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [9:0]  sx [16];
    logic [9:0]  sy [16];
    logic [15:0] act;
    logic        hit_done, spawn_done, hit, sweeping, spawn;
    logic [9:0]  nx, ny;

    enemy_step #(.ENEMY_SPEED(ENEMY_SPEED), .ENEMY_SIZE(ENEMY_SIZE)) u_step (
        .ex(sx[idx]), .ey(sy[idx]), .px(player_x), .py(player_y),
        .bullet_active(bullet_active), .bx(bullet_x), .by(bullet_y),
        .hit(hit), .nx(nx), .ny(ny)
    );

    // Next state, slot index, per-slot strobes and renderer readout
    always_comb begin
        sweeping  = state == SWEEP;
        state_n   = (state == IDLE && tick) ? SWEEP :
                    (sweeping && idx == LAST) ? DONE :
                    (state == DONE) ? IDLE : state;
        idx_n     = (sweeping && idx != LAST) ? idx + 4'd1 : 4'd0;
        busy      = state != IDLE;
        done      = state == DONE;
        hit_pulse = sweeping && act[idx] && hit && !hit_done;
        hit_slot  = hit_pulse ? idx : 4'd0;
        spawn     = sweeping && !act[idx] && spawn_en && !spawn_done;
        rd_active = ({1'b0, rd_idx} < NSLOT) && act[rd_idx];
        rd_x      = sx[rd_idx];
        rd_y      = sy[rd_idx];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    // Slot table, one-hit/one-spawn guards and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx          <= '0;
            act          <= '0;
            hit_done     <= 1'b0;
            spawn_done   <= 1'b0;
            active_count <= '0;
            overrun      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
            end
        end else begin
            idx          <= idx_n;
            overrun      <= overrun | (tick & busy);
            hit_done     <= (state == IDLE) ? 1'b0 : hit_done | hit_pulse;
            spawn_done   <= (state == IDLE) ? 1'b0 : spawn_done | spawn;
            active_count <= active_count + 5'(spawn) - 5'(hit_pulse);
            if (hit_pulse) begin
                act[idx] <= 1'b0;
            end else if (sweeping && act[idx]) begin
                sx[idx] <= nx;
                sy[idx] <= ny;
            end else if (spawn) begin
                act[idx] <= 1'b1;
                sx[idx]  <= rand_val % SPAWN_W;
                sy[idx]  <= rand_val % SPAWN_H;
            end
        end
    end

endmodule

// File: tb/tb_enemy_slot_scheduler.sv
// tb_enemy_slot_scheduler: table-driven sweeps with a slot model and hit scoreboard
module tb_enemy_slot_scheduler;

    localparam int N = 10;

    logic       clk = 0, rst = 0, tick = 0, spawn_en = 0, bullet_active = 0;
    logic [9:0] rand_val = 0, player_x = 0, player_y = 0, bullet_x = 0, bullet_y = 0;
    logic [3:0] rd_idx = 0;
    logic [9:0] rd_x, rd_y;
    logic       rd_active, busy, done, hit_pulse, overrun;
    logic [3:0] hit_slot;
    logic [4:0] active_count;

    int total = 0, bad = 0, ncyc = 0, done_cnt = 0, done_at = -1;
    int hit_q[$];
    bit ma[16];
    int mx[16], my[16];
    int mcnt = 0;

    typedef struct {
        bit sp; int rnd; int px; int py; bit ba; int bx; int by; int cnt;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    enemy_slot_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .spawn_en(spawn_en), .rand_val(rand_val),
        .player_x(player_x), .player_y(player_y), .bullet_active(bullet_active),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_active(rd_active), .busy(busy), .done(done),
        .hit_pulse(hit_pulse), .hit_slot(hit_slot), .active_count(active_count),
        .overrun(overrun)
    );

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Scoreboard side: every hit pulse must match the next expected slot
    always @(negedge clk) if (rst) begin
        if (done) begin
            done_cnt++;
            done_at = ncyc;
        end
        if (hit_pulse) begin
            if (hit_q.size() == 0) chk("unexpected hit_pulse slot", hit_slot, -1);
            else                   chk("hit_slot", hit_slot, hit_q.pop_front());
        end
    end

    function automatic int step(int p, int t, int lim);
        int r;
        if (p < t)      r = (p + 2 < t) ? p + 2 : t;
        else if (p > t) r = (p - 2 > t) ? p - 2 : t;
        else            r = p;
        return (r > lim) ? lim : r;
    endfunction

    task automatic model_sweep();
        bit hd = 0, sd = 0;
        for (int k = 0; k < N; k++) begin
            if (ma[k]) begin
                if (!hd && bullet_active && bullet_x + 5 > mx[k] && bullet_x < mx[k] + 20 &&
                    bullet_y + 10 > my[k] && bullet_y < my[k] + 20) begin
                    ma[k] = 0;
                    hd = 1;
                    hit_q.push_back(k);
                end else begin
                    mx[k] = step(mx[k], player_x, 620);
                    my[k] = step(my[k], player_y, 460);
                end
            end else if (spawn_en && !sd) begin
                ma[k] = 1;
                mx[k] = rand_val % 620;
                my[k] = rand_val % 460;
                sd = 1;
            end
        end
        mcnt = 0;
        for (int k = 0; k < 16; k++) mcnt += ma[k];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            ma[k] = 0;
            mx[k] = 0;
            my[k] = 0;
        end
        mcnt = 0;
        hit_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hit_pulse", hit_pulse, 0);
        chk("reset overrun", overrun, 0);
        chk("reset hit_slot", hit_slot, 0);
        chk("reset active_count", active_count, 0);
        rst = 1;
    endtask

    task automatic run_sweep(input string nm);
        int d0, t1;
        model_sweep();
        d0 = done_cnt;
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        t1 = ncyc;
        chk({nm, " busy"}, busy, 1);
        for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk);
        @(negedge clk);
        chk({nm, " done latency"}, done_at - t1, N);
        chk({nm, " done pulses"}, done_cnt - d0, 1);
        chk({nm, " pending hits"}, hit_q.size(), 0);
    endtask

    task automatic read_slot(input int i, output int a, output int x, output int y);
        @(negedge clk) rd_idx = 4'(i);
        #2;
        a = rd_active;
        x = rd_x;
        y = rd_y;
    endtask

    task automatic check_slots(input string nm);
        int a, x, y;
        for (int i = 0; i < 16; i++) begin
            read_slot(i, a, x, y);
            chk($sformatf("%s slot%0d active", nm, i), a, ma[i]);
            if (ma[i]) begin
                chk($sformatf("%s slot%0d x", nm, i), x, mx[i]);
                chk($sformatf("%s slot%0d y", nm, i), y, my[i]);
            end
        end
        chk($sformatf("%s active_count", nm), active_count, mcnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, x, y, d0;
        tbl[0] = '{1'b1, 500, 100, 100, 1'b0,   0,   0, 1};
        tbl[1] = '{1'b1, 500, 100, 100, 1'b0,   0,   0, 2};
        tbl[2] = '{1'b1, 100, 100, 100, 1'b0,   0,   0, 3};
        tbl[3] = '{1'b1, 500, 100, 100, 1'b0,   0,   0, 4};
        tbl[4] = '{1'b1, 500, 100, 100, 1'b0,   0,   0, 5};
        tbl[5] = '{1'b1, 100, 100, 100, 1'b0,   0,   0, 6};
        tbl[6] = '{1'b0,   0, 100, 200, 1'b1, 105, 105, 5};
        tbl[7] = '{1'b0,   0, 100, 200, 1'b0,   0,   0, 5};
        tbl[8] = '{1'b1,   0, 100, 200, 1'b0,   0,   0, 6};
        tbl[9] = '{1'b0,   0, 100, 200, 1'b1,   0,   0, 5};

        do_reset();
        check_slots("reset");

        spawn_en = 1; rand_val = 700; player_x = 100; player_y = 100;
        run_sweep("first spawn");
        read_slot(0, a, x, y);
        chk("first spawn slot0 active", a, 1);
        chk("first spawn slot0 x", x, 80);
        chk("first spawn slot0 y", y, 240);
        chk("first spawn active_count", active_count, 1);
        check_slots("first spawn");

        do_reset();
        spawn_en = 1; rand_val = 100;
        run_sweep("near spawn");
        spawn_en = 0; player_x = 101; player_y = 300;
        run_sweep("no overshoot");
        read_slot(0, a, x, y);
        chk("no overshoot x", x, 101);
        chk("no overshoot y", y, 102);

        do_reset();
        for (int v = 0; v < 10; v++) begin
            spawn_en = tbl[v].sp;
            rand_val = 10'(tbl[v].rnd);
            player_x = 10'(tbl[v].px);
            player_y = 10'(tbl[v].py);
            bullet_active = tbl[v].ba;
            bullet_x = 10'(tbl[v].bx);
            bullet_y = 10'(tbl[v].by);
            run_sweep($sformatf("vec%0d", v));
            chk($sformatf("vec%0d table count", v), active_count, tbl[v].cnt);
            check_slots($sformatf("vec%0d", v));
            if (v == 6) begin
                read_slot(2, a, x, y);
                chk("hit slot2 cleared", a, 0);
                read_slot(5, a, x, y);
                chk("slot5 still active", a, 1);
                chk("slot5 moved x", x, 100);
                chk("slot5 moved y", y, 102);
            end
        end
        bullet_active = 0;
        spawn_en = 0;

        chk("overrun before", overrun, 0);
        model_sweep();
        d0 = done_cnt;
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        @(negedge clk);
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        chk("overrun set", overrun, 1);
        repeat (30) @(negedge clk);
        chk("overrun single done", done_cnt - d0, 1);
        chk("overrun back idle", busy, 0);
        chk("overrun sticky", overrun, 1);
        check_slots("overrun");

        do_reset();
        spawn_en = 1; rand_val = 619; player_x = 619; player_y = 459;
        run_sweep("edge spawn");
        spawn_en = 0;
        for (int s = 0; s < 150; s++) run_sweep("climb");
        read_slot(0, a, x, y);
        chk("climb x", x, 619);
        chk("climb y", y, 459);
        player_x = 639; player_y = 479;
        run_sweep("clamp");
        read_slot(0, a, x, y);
        chk("clamp x", x, 620);
        chk("clamp y", y, 460);
        check_slots("clamp");

        do_reset();
        spawn_en = 1; rand_val = 700; player_x = 100; player_y = 100;
        d0 = done_cnt;
        @(negedge clk) tick = 1;
        @(negedge clk) tick = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk) rst = 0;
        #2;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort hit_pulse", hit_pulse, 0);
        chk("abort overrun", overrun, 0);
        chk("abort hit_slot", hit_slot, 0);
        chk("abort active_count", active_count, 0);
        rd_idx = 0;
        #1;
        chk("abort slot0 active", rd_active, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        model_reset();
        repeat (15) @(negedge clk);
        chk("abort no done", done_cnt - d0, 0);
        run_sweep("clean");
        read_slot(0, a, x, y);
        chk("clean slot0 x", x, 80);
        chk("clean slot0 y", y, 240);
        check_slots("clean");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_slot_scheduler.md
ENEMY_SLOT_SCHEDULER -- requirements
Module: enemy_slot_scheduler

Interface
REQ-001 Parameter MAX_ENEMIES, default 10, number of enemy slots (legal 2..16).
REQ-002 Parameter ENEMY_SPEED, default 2, pixels moved per axis per sweep.
REQ-003 Parameter ENEMY_SIZE, default 20, square enemy side in pixels; playfield fixed at 640x480.
REQ-004 clk  input  1  system clock; the block's only clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-cycle sweep-start strobe, synchronous to clk.
REQ-007 spawn_en  input  1  enables spawning into inactive slots during a sweep.
REQ-008 rand  input  10  random value from the shared LFSR, sampled only on a spawn cycle.
REQ-009 player_x, player_y  input  10 each  player top-left position.
REQ-010 bullet_active  input  1  bullet is in flight.
REQ-011 bullet_x, bullet_y  input  10 each  bullet top-left; bullet is 5 wide x 10 high.
REQ-012 rd_idx  input  4  renderer slot select.
REQ-013 rd_x, rd_y  output  10 each  selected slot position, combinational from rd_idx.
REQ-014 rd_active  output  1  selected slot active; 0 when rd_idx >= MAX_ENEMIES.
REQ-015 busy  output  1  high while a sweep is in progress.
REQ-016 done  output  1  one-cycle pulse at sweep end.
REQ-017 hit_pulse  output  1  one-cycle pulse when the bullet destroys an enemy.
REQ-018 hit_slot  output  4  index of the destroyed slot, valid with hit_pulse.
REQ-019 active_count  output  5  number of active slots, registered.
REQ-020 overrun  output  1  sticky flag: tick arrived while busy.

Function
REQ-021 FSM states: IDLE, SWEEP, DONE; no other states reachable.
REQ-022 IDLE + tick -> SWEEP with slot index 0; busy rises the cycle after tick.
REQ-023 SWEEP processes exactly one slot per cycle; slot k is updated at cycle T+1+k after a tick at cycle T.
REQ-024 SWEEP with index MAX_ENEMIES-1 -> DONE; DONE asserts done for one cycle (cycle T+1+MAX_ENEMIES), then -> IDLE.
REQ-025 Tick in SWEEP or DONE is ignored and sets overrun; overrun clears only on reset.
REQ-026 Active slot, bullet_active=1, overlap (bx+5 > ex, bx < ex+20, by+10 > ey, by < ey+20) -> slot deactivated, hit_pulse=1, hit_slot=k the same cycle.
REQ-027 At most one hit per sweep: first overlapping slot in ascending index order; later overlapping slots only move.
REQ-028 Active slot, no hit -> each axis moves ENEMY_SPEED toward the player, never overshooting the player coordinate, unchanged when equal.
REQ-029 Moved positions clamp to x <= 640-ENEMY_SIZE, y <= 480-ENEMY_SIZE; coordinates never wrap below 0.
REQ-030 Inactive slot, spawn_en=1, no spawn yet this sweep -> slot active at x = rand mod 620, y = rand mod 460.
REQ-031 At most one spawn per sweep; a slot destroyed in a sweep is not respawned in the same sweep.
REQ-032 Arithmetic in 11-bit unsigned with explicit clamping; no signed 10-bit wrap.
REQ-033 active_count updates in the cycle after each hit or spawn and equals the count of active slots.

Reset
REQ-034 rst low: FSM IDLE, index 0, all slots inactive with x=y=0, busy=done=hit_pulse=overrun=0, hit_slot=0, active_count=0.
REQ-035 rst low mid-sweep aborts the sweep immediately; no done pulse is issued for it.

Structure
REQ-036 Playfield size, enemy size, bullet size, and FSM state encoding are defined in the shared game package.
REQ-037 Per-slot collision and step math is one combinational sub-module, enemy_step, instantiated once and time-shared across slots.

Verification
REQ-038 The bench covers the following directed scenarios.
- Reset, spawn_en=1, rand=700, one tick: slot 0 active at (80,240), only slot 0 spawns, done at T+11, active_count=1.
- Enemy at (100,100), player at (101,300), one tick: enemy moves to (101,102); x does not overshoot.
- Bullet at (105,105), enemies at (100,100) in slot 2 and slot 5: hit_pulse once with hit_slot=2, slot 5 moves, active_count decrements by 1.
- Tick pulses at T and T+3: second tick is ignored, overrun=1, exactly one done pulse.
- Enemy at (619,459), player at (639,479): enemy clamps to (620,460).
- rst low at T+4 of a sweep: all outputs at reset values, no done pulse; next tick starts a clean sweep.
